// File: rtl/nonblock_pkg.sv
// Shared constants for the nonblock delay line: parameter limits and the
// mode encoding that selects a true chain versus a collapsed single-flop chain.
package nonblock_pkg;

  // Upper bounds on the top-level parameters.
  localparam int MAX_DEPTH = 32;
  localparam int MAX_WIDTH = 64;

  // BLOCK_MODE encodings.
  localparam int MODE_CHAIN    = 0;
  localparam int MODE_COLLAPSE = 1;

  // Width of the fill counter: must hold values 0..MAX_DEPTH.
  localparam int FILL_W = $clog2(MAX_DEPTH + 1);

  // Number of edges after reset before the output carries post-reset data.
  // A collapsed chain reaches its output after a single edge.
  function automatic int fill_target(input int depth, input int mode);
    if (mode == MODE_COLLAPSE) begin
      return 1;
    end
    return depth;
  endfunction

endpackage : nonblock_pkg

// File: rtl/nonblock_stage.sv
// One WIDTH-bit register stage of the nonblock delay line, with synchronous
// reset to RST_VAL.
module nonblock_stage
  import nonblock_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Stage register: reset has priority over the incoming sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : nonblock_stage

// File: rtl/nonblock.sv
// Parameterised shift-register delay line. BLOCK_MODE selects either a true
// DEPTH-stage chain (latency DEPTH) or a collapsed chain where every stage
// loads d on the same edge (latency 1). q_valid rises once the output holds
// data sampled after the last reset.
// Optional feature: define NONBLOCK_TAPS_EN to expose every stage on the
// `taps` port (stage i at bits [i*WIDTH +: WIDTH], stage 0 in the LSB slice).
module nonblock
  import nonblock_pkg::*;
#(
  parameter int               DEPTH      = 3,
  parameter int               WIDTH      = 1,
  parameter int               BLOCK_MODE = MODE_CHAIN,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
`ifdef NONBLOCK_TAPS_EN
  output logic [DEPTH*WIDTH-1:0] taps,
`endif
  output logic                   q_valid
);

  // Reject illegal configurations while elaborating.
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $fatal(1, "nonblock: DEPTH=%0d outside legal range 1..%0d", DEPTH, MAX_DEPTH);
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "nonblock: WIDTH=%0d outside legal range 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (BLOCK_MODE != MODE_CHAIN && BLOCK_MODE != MODE_COLLAPSE) begin : g_bad_mode
    $fatal(1, "nonblock: BLOCK_MODE=%0d must be 0 or 1", BLOCK_MODE);
  end

  localparam logic [FILL_W-1:0] FILL_TARGET = FILL_W'(fill_target(DEPTH, BLOCK_MODE));

  // Stage outputs, packed so that stage 0 sits in the least significant slice.
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    // Stage 0 always samples d. In a collapsed chain every stage samples d;
    // otherwise each stage samples its predecessor's registered (pre-edge)
    // value, which is what makes the latency equal to DEPTH.
    if (gi == 0 || BLOCK_MODE == MODE_COLLAPSE) begin : g_from_input
      assign stage_d = d;
    end else begin : g_from_prev
      assign stage_d = stage_q[gi-1];
    end

    nonblock_stage #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .d_i(stage_d),
      .q_o(stage_q[gi])
    );
  end

  assign q = stage_q[DEPTH-1];

`ifdef NONBLOCK_TAPS_EN
  assign taps = stage_q;
`endif

  // Fill counter: edges since reset, saturating at the chain latency.
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;

  // Next fill count: advance until the output carries post-reset data.
  always_comb begin
    fill_d = fill_q;
    if (fill_q < FILL_TARGET) begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  // Fill counter register, cleared by reset together with the stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign q_valid = (fill_q == FILL_TARGET);

endmodule : nonblock

// File: tb/tb_nonblock.sv
// Directed testbench for nonblock. Four instances share clk/rst:
//   dut0 : DEPTH=3 WIDTH=1 chain
//   dut1 : DEPTH=3 WIDTH=1 collapsed
//   dutd1: DEPTH=1 WIDTH=1 chain
//   dut4 : DEPTH=3 WIDTH=4 chain, RST_VAL=4'h6 (taps checked when NONBLOCK_TAPS_EN)
module tb_nonblock;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1  = 1'b0;
  logic [3:0] d4  = 4'h0;

  logic       q0, v0, q1, v1, qd1, vd1, v4;
  logic [3:0] q4;
`ifdef NONBLOCK_TAPS_EN
  logic [2:0]  taps0, taps1;
  logic [0:0]  tapsd1;
  logic [11:0] taps4;
`endif

  int tests  = 0;
  int failed = 0;

  always #20 clk = ~clk;

  nonblock #(.DEPTH(3), .WIDTH(1), .BLOCK_MODE(0), .RST_VAL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .d(d1), .q(q0),
`ifdef NONBLOCK_TAPS_EN
    .taps(taps0),
`endif
    .q_valid(v0));

  nonblock #(.DEPTH(3), .WIDTH(1), .BLOCK_MODE(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .d(d1), .q(q1),
`ifdef NONBLOCK_TAPS_EN
    .taps(taps1),
`endif
    .q_valid(v1));

  nonblock #(.DEPTH(1), .WIDTH(1), .BLOCK_MODE(0), .RST_VAL(1'b0)) dutd1 (
    .clk(clk), .rst(rst), .d(d1), .q(qd1),
`ifdef NONBLOCK_TAPS_EN
    .taps(tapsd1),
`endif
    .q_valid(vd1));

  nonblock #(.DEPTH(3), .WIDTH(4), .BLOCK_MODE(0), .RST_VAL(4'h6)) dut4 (
    .clk(clk), .rst(rst), .d(d4), .q(q4),
`ifdef NONBLOCK_TAPS_EN
    .taps(taps4),
`endif
    .q_valid(v4));

  // Reset for two edges with d=1, then release and watch the fill.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; d1 = 1'b1; d4 = 4'hF;
    repeat (2) @(negedge clk);
    tests++; if (q0 !== 1'b0)  begin failed++; $display("FAIL reset_q0: got %b expected 0", q0); end
    tests++; if (v0 !== 1'b0)  begin failed++; $display("FAIL reset_v0: got %b expected 0", v0); end
    tests++; if (q1 !== 1'b0)  begin failed++; $display("FAIL reset_q1: got %b expected 0", q1); end
    tests++; if (v1 !== 1'b0)  begin failed++; $display("FAIL reset_v1: got %b expected 0", v1); end
    tests++; if (q4 !== 4'h6)  begin failed++; $display("FAIL reset_q4: got %h expected 6", q4); end
    $display("[TB] reset held 2 edges: q0=%b v0=%b q1=%b v1=%b q4=%h", q0, v0, q1, v1, q4);
    rst = 1'b0;
    @(negedge clk);  // edge 1 after release
    tests++; if (v0 !== 1'b0)  begin failed++; $display("FAIL fill1_v0: got %b expected 0", v0); end
    tests++; if (v1 !== 1'b1)  begin failed++; $display("FAIL fill1_v1: got %b expected 1", v1); end
    tests++; if (vd1 !== 1'b1) begin failed++; $display("FAIL fill1_vd1: got %b expected 1", vd1); end
    @(negedge clk);  // edge 2
    tests++; if (v0 !== 1'b0)  begin failed++; $display("FAIL fill2_v0: got %b expected 0", v0); end
    tests++; if (q0 !== 1'b0)  begin failed++; $display("FAIL fill2_q0: got %b expected 0", q0); end
    @(negedge clk);  // edge 3
    tests++; if (v0 !== 1'b1)  begin failed++; $display("FAIL fill3_v0: got %b expected 1", v0); end
    tests++; if (q0 !== 1'b1)  begin failed++; $display("FAIL fill3_q0: got %b expected 1", q0); end
    tests++; if (v4 !== 1'b1)  begin failed++; $display("FAIL fill3_v4: got %b expected 1", v4); end
    $display("[TB] fill after release: v0=%b q0=%b v1=%b", v0, q0, v1);
  endtask

  // d=0 for 8 edges, then step to 1 and track arrival in each mode.
  task automatic test_step();
    d1 = 1'b0;
    repeat (8) @(negedge clk);
    tests++; if (q0 !== 1'b0) begin failed++; $display("FAIL step_pre_q0: got %b expected 0", q0); end
    tests++; if (q1 !== 1'b0) begin failed++; $display("FAIL step_pre_q1: got %b expected 0", q1); end
    d1 = 1'b1;
    @(negedge clk);  // first edge sampling 1
    tests++; if (q0 !== 1'b0)  begin failed++; $display("FAIL step_e1_q0: got %b expected 0", q0); end
    tests++; if (q1 !== 1'b1)  begin failed++; $display("FAIL step_e1_q1: got %b expected 1", q1); end
    tests++; if (qd1 !== 1'b1) begin failed++; $display("FAIL step_e1_qd1: got %b expected 1", qd1); end
    @(negedge clk);
    tests++; if (q0 !== 1'b0)  begin failed++; $display("FAIL step_e2_q0: got %b expected 0", q0); end
    @(negedge clk);
    tests++; if (q0 !== 1'b1)  begin failed++; $display("FAIL step_e3_q0: got %b expected 1", q0); end
    $display("[TB] step: q0=%b q1=%b qd1=%b after 3 edges of d=1", q0, q1, qd1);
  endtask

  // d changes every 50 time units against a 40-unit clock; q must track the
  // sequence sampled at each edge and hold steady between edges.
  task automatic test_alternating();
    logic seq [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic hist [$];
    // Chain currently holds all ones (d=1 for at least three edges).
    hist.push_back(1'b1);
    hist.push_back(1'b1);
    @(negedge clk);
    #5;
    fork
      begin
        for (int k = 0; k < 7; k++) begin
          d1 = seq[k];
          #50;
        end
      end
      begin
        for (int n = 0; n < 9; n++) begin
          int m;
          logic e0, e1;
          @(posedge clk);
          hist.push_back(d1);
          m  = hist.size();
          e0 = hist[m-3];
          e1 = hist[m-1];
          #1;
          tests++; if (q0 !== e0) begin failed++; $display("FAIL alt_q0_e%0d: got %b expected %b", n, q0, e0); end
          tests++; if (q1 !== e1) begin failed++; $display("FAIL alt_q1_e%0d: got %b expected %b", n, q1, e1); end
          #30;
          tests++; if (q0 !== e0 || q1 !== e1) begin
            failed++; $display("FAIL alt_hold_e%0d: got q0=%b q1=%b expected %b %b", n, q0, q1, e0, e1);
          end
          $display("[TB] alt edge %0d: sampled d=%b q0=%b q1=%b", n, hist[m-1], q0, q1);
        end
      end
    join
  endtask

  // Load 1,0,1 into the chain, reset for one edge, then refill.
  task automatic test_midreset();
    @(negedge clk);
    d1 = 1'b1; @(negedge clk);
    d1 = 1'b0; @(negedge clk);
    d1 = 1'b1; @(negedge clk);
    tests++; if (q0 !== 1'b1) begin failed++; $display("FAIL mid_load_q0: got %b expected 1", q0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (q0 !== 1'b0) begin failed++; $display("FAIL mid_rst_q0: got %b expected 0", q0); end
    tests++; if (v0 !== 1'b0) begin failed++; $display("FAIL mid_rst_v0: got %b expected 0", v0); end
    tests++; if (q1 !== 1'b0) begin failed++; $display("FAIL mid_rst_q1: got %b expected 0", q1); end
    tests++; if (v1 !== 1'b0) begin failed++; $display("FAIL mid_rst_v1: got %b expected 0", v1); end
    @(negedge clk);
    tests++; if (q0 !== 1'b0 || v0 !== 1'b0) begin failed++; $display("FAIL mid_e1_dut0: got q=%b v=%b expected 0 0", q0, v0); end
    tests++; if (q1 !== 1'b1 || v1 !== 1'b1) begin failed++; $display("FAIL mid_e1_dut1: got q=%b v=%b expected 1 1", q1, v1); end
    @(negedge clk);
    tests++; if (q0 !== 1'b0 || v0 !== 1'b0) begin failed++; $display("FAIL mid_e2_dut0: got q=%b v=%b expected 0 0", q0, v0); end
    @(negedge clk);
    tests++; if (q0 !== 1'b1 || v0 !== 1'b1) begin failed++; $display("FAIL mid_e3_dut0: got q=%b v=%b expected 1 1", q0, v0); end
    $display("[TB] mid-run reset refill: q0=%b v0=%b", q0, v0);
  endtask

  // 4-bit chain with nonzero reset value; feed A,5,F.
  task automatic test_taps();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (q4 !== 4'h6 || v4 !== 1'b0) begin failed++; $display("FAIL taps_rst: got q=%h v=%b expected 6 0", q4, v4); end
`ifdef NONBLOCK_TAPS_EN
    tests++; if (taps4 !== 12'h666) begin failed++; $display("FAIL taps_rst_taps: got %h expected 666", taps4); end
`endif
    d4 = 4'hA; @(negedge clk);
    d4 = 4'h5; @(negedge clk);
    tests++; if (q4 !== 4'h6) begin failed++; $display("FAIL taps_e2_q4: got %h expected 6", q4); end
`ifdef NONBLOCK_TAPS_EN
    tests++; if (taps4 !== 12'h6A5) begin failed++; $display("FAIL taps_e2_taps: got %h expected 6A5", taps4); end
`endif
    d4 = 4'hF; @(negedge clk);
    tests++; if (q4 !== 4'hA || v4 !== 1'b1) begin failed++; $display("FAIL taps_e3_q4: got q=%h v=%b expected A 1", q4, v4); end
`ifdef NONBLOCK_TAPS_EN
    tests++; if (taps4 !== 12'hA5F) begin failed++; $display("FAIL taps_e3_taps: got %h expected A5F", taps4); end
`endif
    d4 = 4'h0; @(negedge clk);
    tests++; if (q4 !== 4'h5) begin failed++; $display("FAIL taps_e4_q4: got %h expected 5", q4); end
    $display("[TB] wide chain: q4=%h v4=%b", q4, v4);
  endtask

  initial begin
    test_reset();
    test_step();
    test_alternating();
    test_midreset();
    test_taps();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_nonblock

// File: doc/nonblock.md
Name: nonblock

Overview:
- Parameterised single-clock shift-register delay line (D-flop chain) that delays input `d` by a fixed number of clock cycles.
- Reference implementation of a correct multi-stage register chain, where every stage samples its predecessor's pre-edge value.
- `BLOCK_MODE=1` reproduces the degenerate "block" behaviour: the chain collapses to a single flop.
- Sits as a leaf utility: synchroniser-style delay, pipeline alignment, teaching/regression pair for blocking vs non-blocking semantics.

Parameters:
- DEPTH, 3: number of register stages; legal range 1..32.
- WIDTH, 1: data width in bits; legal range 1..64.
- BLOCK_MODE, 0:
  - 0 = true DEPTH-stage chain (latency DEPTH).
  - 1 = collapsed chain: all stages load `d` on the same edge (latency 1). Matches the blocking-assignment variant.
- RST_VAL, 0: value every stage takes on reset; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d  input  WIDTH  data in.
- q  output  WIDTH  data out (last stage).
- q_valid  output  1  high once the chain is filled with post-reset data.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk` only.
- Reset:
  - When `rst`=1 at a rising edge, all stages load RST_VAL.
  - `q` = RST_VAL and `q_valid` = 0 from that edge.
  - Reset wins over data on the same edge.
- BLOCK_MODE=0, each rising edge with `rst`=0:
  - stage[0] <= d.
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1.
  - q = stage[DEPTH-1].
  - All stages use pre-edge values; no stage may see a value written on the same edge.
  - Latency: a value on `d` at edge N appears on `q` after edge N+DEPTH-1, i.e. DEPTH edges after it is first sampled.
- BLOCK_MODE=1:
  - Every stage loads `d` on each edge, so q = value of `d` sampled at the most recent edge (latency 1).
  - Stage registers still exist and all hold identical values.
- q_valid:
  - A fill counter counts edges since reset, saturating at DEPTH (or at 1 in BLOCK_MODE=1).
  - q_valid = 1 when the counter has saturated.
  - Reset mid-operation clears the counter and all stages.
- `d` changing between edges has no effect until the next edge. No asynchronous paths from `d` to `q`.
- DEPTH=1: both modes are identical, single flop.
- Outputs are registered (q) or decoded from registered state (q_valid); no combinational path from inputs to outputs.
- Illegal parameters (DEPTH<1, WIDTH<1) are rejected at elaboration with a fatal message.

Optional Feature:
- Macro NONBLOCK_TAPS_EN.
- Defined: adds output port `taps` [DEPTH*WIDTH-1:0] exposing every stage. Stage i occupies bits [i*WIDTH +: WIDTH]; stage 0 is the LSB slice.
- Undefined: port absent, and intermediate stages are internal only. Core behaviour is identical in both cases.

Decomposition:
- Shared package `nonblock_pkg` holds:
  - MAX_DEPTH=32 and MAX_WIDTH=64 constants.
  - the mode encoding localparams MODE_CHAIN=0 and MODE_COLLAPSE=1.
- One natural sub-module, `nonblock_stage`: a single WIDTH-bit flop with synchronous reset to RST_VAL. Instantiated DEPTH times via generate.
- The fill counter and q_valid logic stay in the top.

Test Plan:
- Reset: rst=1 for 2 edges with d=1 -> q=0, q_valid=0. Release; q_valid rises after the 3rd edge (DEPTH=3).
- Step, DEPTH=3, BLOCK_MODE=0: after reset, d=0 for 8 edges, then d=1 -> q stays 0 for 2 more edges and becomes 1 on the 3rd edge after `d` is first sampled high.
- Same step with BLOCK_MODE=1 -> q becomes 1 on the first edge that samples d=1.
- Alternating pattern, DEPTH=3, clk period 40, d changing every 50: d=1,1,1,0,1,0,1 -> q reproduces the sampled sequence exactly 3 edges late in mode 0 and 1 edge late in mode 1, with no glitch between edges.
- Mid-run reset: assert rst for 1 edge while the chain holds 1,0,1 -> all stages 0 next edge, q_valid=0, and refill takes DEPTH edges.
- With NONBLOCK_TAPS_EN, WIDTH=4, DEPTH=3: feed 0xA, 0x5, 0xF -> taps = 0xA5F (stage0=0xF, stage1=0x5, stage2=0xA) and q=0xA.
